// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - timed staged reset release with soft/watchdog re-sequencing and cause capture
// Optional RSTSEQ_REVERSE_ASSERT_EN: soft/watchdog resets drain stages high-to-low before re-sequencing.
module rst_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DLY   = 16,
  parameter int DLY_W       = 8,
  parameter int WDT_TIMEOUT = 50000,
  parameter int WDT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_rst_req,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  ready,
  output logic                  busy,
  output logic [1:0]            cause
);

`ifdef RSTSEQ_REVERSE_ASSERT_EN
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, DRAIN} state_t;
`else
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
`endif

  localparam logic [DLY_W-1:0]      DLY_FULL  = DLY_W'(STAGE_DLY);
  localparam logic [DLY_W-1:0]      DLY_LAST  = DLY_W'(STAGE_DLY - 1);
  localparam logic [WDT_W-1:0]      WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_LSB = NUM_STAGES'(1);

  state_t                  state_q, state_d;
  logic [DLY_W-1:0]        dly_q, dly_d;
  logic [WDT_W-1:0]        wdt_q, wdt_d;
  logic [1:0]              cause_d;
  logic [NUM_STAGES-1:0]   stage_d;
  logic                    ready_d, busy_d;
  logic                    wdt_fire;
  logic [1:0]              sync_q;
  logic                    soft_prev_q, soft_flag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  // Flag only edges seen while running so requests in HOLD/RELEASE are dropped, not queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soft_prev_q <= 1'b0;
      soft_flag_q <= 1'b0;
    end else begin
      soft_prev_q <= soft_rst_req;
      soft_flag_q <= soft_rst_req & ~soft_prev_q & (state_q == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      dly_q       <= '0;
      wdt_q       <= '0;
      stage_rst_n <= '0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      cause       <= 2'b00;
    end else if (!sync_q[1]) begin
      state_q     <= HOLD;
      dly_q       <= '0;
      wdt_q       <= '0;
      stage_rst_n <= '0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      cause       <= 2'b00;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      wdt_q       <= wdt_d;
      stage_rst_n <= stage_d;
      ready       <= ready_d;
      busy        <= busy_d;
      cause       <= cause_d;
    end
  end

  // Re-entered HOLD starts at 1: power-up spends that extra cycle leaving the synchronizer.
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    wdt_d    = '0;
    cause_d  = cause;
    wdt_fire = 1'b0;
    case (state_q)
      HOLD: begin
        if (dly_q == DLY_FULL) begin
          state_d = RELEASE;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      RELEASE: begin
        if (stage_rst_n[NUM_STAGES-1]) begin
          state_d = RUN;
          dly_d   = '0;
        end else if (dly_q == DLY_LAST) begin
          dly_d = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      RUN: begin
        if (wdt_kick)               wdt_d = '0;
        else if (wdt_q == WDT_LAST) wdt_fire = 1'b1;
        else                        wdt_d = wdt_q + WDT_W'(1);
        if (wdt_fire || soft_flag_q) begin
          cause_d = wdt_fire ? 2'b10 : 2'b01;
          wdt_d   = '0;
`ifdef RSTSEQ_REVERSE_ASSERT_EN
          state_d = DRAIN;
          dly_d   = '0;
`else
          state_d = HOLD;
          dly_d   = DLY_W'(1);
`endif
        end
      end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      DRAIN: begin
        if (!stage_rst_n[0]) begin
          state_d = HOLD;
          dly_d   = DLY_W'(1);
        end else if (dly_q == DLY_LAST) begin
          dly_d = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
`endif
      default: begin
        state_d = HOLD;
        dly_d   = '0;
      end
    endcase
  end

  always_comb begin
    stage_d = stage_rst_n;
    case (state_q)
      HOLD:    stage_d = (state_d == RELEASE) ? STAGE_LSB : '0;
      RELEASE: begin
        if (!stage_rst_n[NUM_STAGES-1] && dly_q == DLY_LAST)
          stage_d = (stage_rst_n << 1) | STAGE_LSB;
      end
      RUN: begin
        if (state_d != RUN)
`ifdef RSTSEQ_REVERSE_ASSERT_EN
          stage_d = stage_rst_n >> 1;
`else
          stage_d = '0;
`endif
      end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      DRAIN: begin
        if (stage_rst_n[0] && dly_q == DLY_LAST)
          stage_d = stage_rst_n >> 1;
      end
`endif
      default: stage_d = '0;
    endcase
    ready_d = (state_d == RUN);
    busy_d  = ~ready_d;
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer (STAGE_DLY=4, WDT_TIMEOUT=20)
module tb_rst_sequencer;

`ifdef RSTSEQ_REVERSE_ASSERT_EN
  localparam int         DX           = 9;
  localparam logic [2:0] FIRST_ASSERT = 3'b011;
`else
  localparam int         DX           = 0;
  localparam logic [2:0] FIRST_ASSERT = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic [2:0] stage_rst_n;
  logic       ready;
  logic       busy;
  logic [1:0] cause;

  int checks = 0;
  int fails  = 0;

  rst_sequencer #(
    .NUM_STAGES(3), .STAGE_DLY(4), .DLY_W(8), .WDT_TIMEOUT(20), .WDT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .soft_rst_req(soft_rst_req), .wdt_kick(wdt_kick),
    .stage_rst_n(stage_rst_n), .ready(ready), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++; fails++;
      $display("FAIL wait_ready timeout ready=%b want 1", ready);
    end
  endtask

  task automatic wait_stage(input logic [2:0] v);
    int n = 0;
    while (stage_rst_n !== v && n < 300) begin
      tick(1);
      n++;
    end
    if (stage_rst_n !== v) begin
      checks++; fails++;
      $display("FAIL wait_stage timeout stage=%b want %b", stage_rst_n, v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if (stage_rst_n !== 3'b000 || ready !== 1'b0 || busy !== 1'b1 || cause !== 2'b00) begin
      fails++;
      $display("FAIL reset_values stage=%b ready=%b busy=%b cause=%b want 000 0 1 00",
               stage_rst_n, ready, busy, cause);
    end
  endtask

  task automatic test_powerup();
    logic [2:0] es;
    logic       er;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    for (int c = 1; c <= 15; c++) begin
      tick(1);
      es = (c >= 14) ? 3'b111 : (c >= 10) ? 3'b011 : (c >= 6) ? 3'b001 : 3'b000;
      er = (c >= 15);
      checks++;
      if (stage_rst_n !== es || ready !== er || busy !== ~er) begin
        fails++;
        $display("FAIL powerup t0+%0d stage=%b ready=%b busy=%b want %b %b %b",
                 c, stage_rst_n, ready, busy, es, er, ~er);
      end
    end
    checks++;
    if (cause !== 2'b00) begin
      fails++;
      $display("FAIL powerup_cause cause=%b want 00", cause);
    end
  endtask

  task automatic test_watchdog();
    wdt_kick = 1'b0;
    for (int k = 1; k <= 24 + DX; k++) begin
      tick(1);
      if (k == 19) begin
        checks++;
        if (stage_rst_n !== 3'b111 || ready !== 1'b1) begin
          fails++;
          $display("FAIL wdt_before E+19 stage=%b ready=%b want 111 1", stage_rst_n, ready);
        end
      end
      if (k == 20) begin
        checks++;
        if (stage_rst_n !== FIRST_ASSERT || ready !== 1'b0 || busy !== 1'b1 || cause !== 2'b10) begin
          fails++;
          $display("FAIL wdt_fire E+20 stage=%b ready=%b busy=%b cause=%b want %b 0 1 10",
                   stage_rst_n, ready, busy, cause, FIRST_ASSERT);
        end
      end
      if (k == 23 + DX) begin
        checks++;
        if (stage_rst_n !== 3'b000) begin
          fails++;
          $display("FAIL wdt_hold E+%0d stage=%b want 000", k, stage_rst_n);
        end
      end
      if (k == 24 + DX) begin
        checks++;
        if (stage_rst_n !== 3'b001) begin
          fails++;
          $display("FAIL wdt_rerelease E+%0d stage=%b want 001", k, stage_rst_n);
        end
      end
    end
    wait_ready();
  endtask

  task automatic test_kick();
    logic dropped = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      wdt_kick = (i % 10 == 0);
      tick(1);
      if (ready !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped !== 1'b0) begin
      fails++;
      $display("FAIL kick_periodic ready dropped=%b want 0", dropped);
    end
    wdt_kick = 1'b0;
    tick(19);
    wdt_kick = 1'b1;
    tick(1);
    checks++;
    if (ready !== 1'b1 || stage_rst_n !== 3'b111) begin
      fails++;
      $display("FAIL kick_at_19 ready=%b stage=%b want 1 111", ready, stage_rst_n);
    end
    wdt_kick = 1'b0;
    tick(19);
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL kick_restart_early ready=%b want 1", ready);
    end
    tick(1);
    checks++;
    if (ready !== 1'b0 || cause !== 2'b10) begin
      fails++;
      $display("FAIL kick_restart_fire ready=%b cause=%b want 0 10", ready, cause);
    end
    wdt_kick = 1'b1;
    wait_ready();
  endtask

  task automatic test_soft_held();
    logic seen_back = 1'b0;
    logic second    = 1'b0;
    wdt_kick = 1'b1;
    soft_rst_req = 1'b1;
    tick(1);
    checks++;
    if (stage_rst_n !== 3'b111 || ready !== 1'b1) begin
      fails++;
      $display("FAIL soft_edge_N stage=%b ready=%b want 111 1", stage_rst_n, ready);
    end
    tick(1);
    checks++;
    if (stage_rst_n !== FIRST_ASSERT || cause !== 2'b01 || ready !== 1'b0) begin
      fails++;
      $display("FAIL soft_N+1 stage=%b cause=%b ready=%b want %b 01 0",
               stage_rst_n, cause, ready, FIRST_ASSERT);
    end
    for (int i = 0; i < 28; i++) begin
      tick(1);
      if (ready === 1'b1) seen_back = 1'b1;
      else if (seen_back) second = 1'b1;
    end
    checks++;
    if (seen_back !== 1'b1 || second !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL soft_held_once back=%b second=%b ready=%b want 1 0 1", seen_back, second, ready);
    end
    soft_rst_req = 1'b0;
    tick(1);
  endtask

  task automatic test_simultaneous();
    wdt_kick = 1'b0;
    tick(18);
    soft_rst_req = 1'b1;
    tick(1);
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL simul_pre ready=%b want 1", ready);
    end
    tick(1);
    checks++;
    if (cause !== 2'b10 || stage_rst_n !== FIRST_ASSERT || ready !== 1'b0) begin
      fails++;
      $display("FAIL simul_cause cause=%b stage=%b ready=%b want 10 %b 0", cause, stage_rst_n, ready, FIRST_ASSERT);
    end
    soft_rst_req = 1'b0;
    wdt_kick = 1'b1;
    tick(5 + DX);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(2);
    checks++;
    if (stage_rst_n !== 3'b011) begin
      fails++;
      $display("FAIL release_ignore H+8 stage=%b want 011", stage_rst_n);
    end
    tick(4);
    checks++;
    if (stage_rst_n !== 3'b111 || ready !== 1'b0) begin
      fails++;
      $display("FAIL release_ignore H+12 stage=%b ready=%b want 111 0", stage_rst_n, ready);
    end
    tick(1);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL release_ignore H+13 ready=%b busy=%b want 1 0", ready, busy);
    end
    tick(3);
    checks++;
    if (ready !== 1'b1 || stage_rst_n !== 3'b111) begin
      fails++;
      $display("FAIL release_not_queued ready=%b stage=%b want 1 111", ready, stage_rst_n);
    end
  endtask

  task automatic test_master_mid();
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    wait_stage(3'b000);
    wait_stage(3'b011);
    #3;
    checks++;
    if (cause !== 2'b01 || busy !== 1'b1) begin
      fails++;
      $display("FAIL master_pre cause=%b busy=%b want 01 1", cause, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (stage_rst_n !== 3'b000 || cause !== 2'b00 || busy !== 1'b1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL master_async stage=%b cause=%b busy=%b ready=%b want 000 00 1 0",
               stage_rst_n, cause, busy, ready);
    end
    tick(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready();
    checks++;
    if (cause !== 2'b00 || stage_rst_n !== 3'b111) begin
      fails++;
      $display("FAIL master_recover cause=%b stage=%b want 00 111", cause, stage_rst_n);
    end
  endtask

`ifdef RSTSEQ_REVERSE_ASSERT_EN
  task automatic test_reverse();
    logic [2:0] exp_s [5] = '{3'b011, 3'b001, 3'b000, 3'b000, 3'b001};
    int         at    [5] = '{0, 4, 8, 12, 13};
    int         d = 0;
    wdt_kick = 1'b1;
    soft_rst_req = 1'b1;
    tick(2);
    soft_rst_req = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick(at[j] - d);
      d = at[j];
      checks++;
      if (stage_rst_n !== exp_s[j] || ready !== 1'b0 || cause !== 2'b01) begin
        fails++;
        $display("FAIL reverse D+%0d stage=%b ready=%b cause=%b want %b 0 01",
                 at[j], stage_rst_n, ready, cause, exp_s[j]);
      end
    end
    wait_ready();
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_watchdog();
    test_kick();
    test_soft_held();
    test_simultaneous();
    test_master_mid();
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    test_reverse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the master active-low reset and releases a set of subsystem resets in a fixed, timed order: clock/PLL-dependent logic first, then MIDI UARTs, then the routing matrix.
- Also re-enters the reset sequence on a software request or a watchdog timeout.
- Records why the last reset sequence happened, so firmware can read the cause.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (1..8).
- STAGE_DLY, 16, clk cycles between successive stage releases (≥2).
- DLY_W, 8, width of the stage delay counter; must satisfy STAGE_DLY ≤ 2^DLY_W-1.
- WDT_TIMEOUT, 50000, clk cycles in RUN without a kick before a watchdog reset (≥2).
- WDT_W, 16, width of the watchdog counter; must satisfy WDT_TIMEOUT ≤ 2^WDT_W.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  master reset; asynchronous assert, active-low.
- soft_rst_req  input  1  software reset request, synchronous to clk; rising edge acts.
- wdt_kick  input  1  watchdog service strobe, synchronous to clk.
- stage_rst_n  output  NUM_STAGES  per-subsystem active-low resets; bit 0 is released first.
- ready  output  1  high when all stages are released and the block is in RUN.
- busy  output  1  high whenever state is not RUN.
- cause  output  2  cause of the last sequence: 00 master, 01 soft, 10 watchdog, 11 unused.

Behaviour:
- **Reset values and clocking.** One clock; reset is asynchronous and active-low on reset_n. While reset_n=0:
  - stage_rst_n=0 (all bits), ready=0, busy=1, cause=00.
  - state=HOLD, all counters 0.
- **Deassertion synchronizer.** reset_n deassertion passes through a 2-FF synchronizer; assertion is immediate and asynchronous.
  - t0 = first clk edge at which reset_n is sampled high.
  - The internal synchronized reset releases at t0+1.
- **State HOLD.**
  - All stage_rst_n low.
  - The delay counter counts STAGE_DLY cycles, then the block goes to RELEASE and sets stage_rst_n[0]=1.
- **State RELEASE.**
  - Every STAGE_DLY cycles the next stage bit goes high. Bits only go 0→1, in index order.
  - After stage NUM_STAGES-1 is released, the next edge enters RUN: ready=1, busy=0.
- **Power-up timing.** stage_rst_n[k] rises at edge t0+2+(k+1)*STAGE_DLY; ready rises one edge after the last stage.
- **State RUN.**
  - *Watchdog counter.* Cleared on RUN entry. Increments each cycle without wdt_kick; wdt_kick clears it to 0.
  - *Timeout.* When the counter is WDT_TIMEOUT-1 and wdt_kick=0, the next edge asserts all stage_rst_n=0, sets ready=0, busy=1, cause=10, and enters HOLD.
  - *Kick vs timeout.* A kick in the same cycle as the timeout condition wins; no reset occurs.
- **Soft request.**
  - A registered edge detector flags soft_rst_req=1 when the previous sample was 0.
  - If the flag is seen in RUN, the next edge asserts all stages, sets cause=01, and enters HOLD. This is a one-cycle latency from the sampled edge.
  - A request held high triggers only once. Re-arming needs a low sample.
- **Simultaneous soft and watchdog events:** watchdog takes priority, cause=10.
- **Soft sequences:** soft and watchdog sequences rerun HOLD and RELEASE with the same STAGE_DLY timing, without the 2-cycle synchronizer delay.
- **Requests outside RUN:** soft_rst_req edges and wdt_kick in HOLD or RELEASE are ignored and not queued; the watchdog is frozen at 0.
- **Master reset mid-operation:** reset_n assertion in any state immediately forces reset values, including cause=00.
- **Output registration:** all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RSTSEQ_REVERSE_ASSERT_EN.
- **Defined:**
  - Soft and watchdog resets enter a DRAIN state that asserts stages in reverse order.
  - The highest bit goes low at the first edge, then the next-lower bit every STAGE_DLY cycles.
  - ready and busy change at the first edge; cause is set at the first edge.
  - After bit 0 goes low, the next edge enters HOLD.
  - Master reset is still immediate and all-at-once.
- **Undefined:** all stages are asserted simultaneously, as described above; no DRAIN state is synthesized.

Test Plan:
- Power-up, NUM_STAGES=3, STAGE_DLY=4: release reset_n before an edge, so t0 = that edge → stage_rst_n 000→001 at t0+6, 011 at t0+10, 111 at t0+14; ready=1 and busy=0 at t0+15; cause=00.
- Watchdog, WDT_TIMEOUT=20, no kicks, ready rises at edge E → stage_rst_n=000, ready=0, cause=10 at E+20. Re-release starts from HOLD: bit 0 at E+24.
- Kick every 10 cycles for 500 cycles → no reset. Then a kick coincident with counter=19 → no reset at the following edge.
- soft_rst_req held high 30 cycles in RUN, sampled high at edge N → stages low at N+1, cause=01. Exactly one sequence, no second sequence after return to RUN while still held.
- soft_rst_req edge and watchdog timeout in the same cycle → cause=10. A soft edge during RELEASE → ignored; timing unchanged.
- reset_n asserted mid-RELEASE (stage_rst_n=011) → asynchronously 000, cause=00, busy=1 without waiting for a clk edge. With RSTSEQ_REVERSE_ASSERT_EN and STAGE_DLY=4, a soft reset gives 011 at edge D, 001 at D+4, 000 at D+8, HOLD at D+9.
